tone_mixer: RTL and testbench

- Parametrised successor to the fixed sound_controller: CHANNELS independent square-wave tone channels, each triggered with a tone code.
- Each channel plays its tone for a fixed duration, then observes a silent gap.
- Active channels are mixed by a first-order sigma-delta modulator into the single 1-bit sound output.
- Sits beside the vga_controller in top, on the 12 MHz system clock; driven by game logic (mute / trigger / code).

---
 rtl/tone_mixer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_tone_mixer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tone_mixer
//  Purpose  : CHANNELS independent square-wave tone channels. Each channel
//             plays a latched tone code for DUR_MS milliseconds, then holds a
//             GAP_MS silent gap. The active tone bits are mixed by a
//             first-order sigma-delta modulator onto one 1-bit sound output.
//  Revision : 1.0  initial parametrised release (successor to sound_controller)
// ============================================================================
module tone_mixer #(
    parameter int CLK_HZ    = 12000000,
    parameter int CHANNELS  = 2,
    parameter int CODE_W    = 2,
    parameter int BASE_HALF = 13636,
    parameter int DUR_MS    = 100,
    parameter int GAP_MS    = 20
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         mute,
    input  logic [CHANNELS-1:0]          trig,
    input  logic [CHANNELS*CODE_W-1:0]   code,
    output logic [CHANNELS-1:0]          busy,
    output logic [CODE_W-1:0]            code_sound,
    output logic                         sound
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int MS_DIV  = CLK_HZ / 1000;
    localparam int PRE_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int HALF_W  = $clog2(BASE_HALF + 1);
    localparam int DMAX    = (DUR_MS > GAP_MS) ? DUR_MS : GAP_MS;
    localparam int DUR_W   = $clog2(DMAX + 1);
    localparam int LVL_W   = $clog2(CHANNELS + 1);
    localparam int ACC_W   = $clog2(2 * CHANNELS);
    localparam int SUM_W   = ACC_W + 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_MS - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_MS - 1);
    localparam logic [SUM_W-1:0] CH_SUM   = SUM_W'(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } ch_state_t;

    // Half-period for a non-zero code k is BASE_HALF >> (k-1), never below 1
    // so that the tone counter always has a valid wrap point.
    function automatic logic [HALF_W-1:0] half_of(input logic [CODE_W-1:0] c);
        logic [HALF_W-1:0] h;
        h = HALF_W'(BASE_HALF >> (32'(c) - 32'd1));
        if (h == '0) begin
            h = HALF_W'(1);
        end
        return h;
    endfunction

    // ------------------------------------------------------------------------
    // Millisecond prescaler, shared by every channel
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt;
    logic             ms_tick;

    assign ms_tick = (pre_cnt == PRE_LAST);

    // Free-running 0..MS_DIV-1 counter; ms_tick marks the wrap cycle.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre_cnt <= '0;
        end else if (ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Tone channels
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] tone_bits;
    logic [CHANNELS-1:0] play_nxt;
    logic [CODE_W-1:0]   code_nxt [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CODE_W-1:0] code_in;
        ch_state_t         state;
        ch_state_t         state_nxt;
        logic [CODE_W-1:0] code_q;
        logic [HALF_W-1:0] half_q;
        logic [HALF_W-1:0] tone_cnt;
        logic [DUR_W-1:0]  dur_cnt;
        logic              tone;
        logic              start;
        logic              dur_done;

        assign code_in = code[i*CODE_W +: CODE_W];

        // Next-state decode: start on a non-zero trigger, leave PLAY/GAP on
        // the ms tick that brings the duration count to its limit.
        always_comb begin
            state_nxt = state;
            start     = 1'b0;
            dur_done  = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trig[i] && (code_in != '0)) begin
                        start     = 1'b1;
                        state_nxt = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (ms_tick && (dur_cnt == DUR_LAST)) begin
                        dur_done  = 1'b1;
                        state_nxt = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (ms_tick && (dur_cnt == GAP_LAST)) begin
                        dur_done  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // Channel state register.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                state <= ST_IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        // Channel datapath: code/half-period latch, tone and duration counters.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                code_q   <= '0;
                half_q   <= '0;
                tone_cnt <= '0;
                dur_cnt  <= '0;
                tone     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            code_q   <= code_in;
                            half_q   <= half_of(code_in);
                            tone_cnt <= '0;
                            dur_cnt  <= '0;
                            tone     <= 1'b0;
                        end
                    end
                    ST_PLAY: begin
                        if (dur_done) begin
                            tone     <= 1'b0;
                            tone_cnt <= '0;
                            dur_cnt  <= '0;
                        end else begin
                            if (tone_cnt == (half_q - HALF_W'(1))) begin
                                tone_cnt <= '0;
                                tone     <= ~tone;
                            end else begin
                                tone_cnt <= tone_cnt + HALF_W'(1);
                            end
                            if (ms_tick) begin
                                dur_cnt <= dur_cnt + DUR_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        tone <= 1'b0;
                        if (dur_done) begin
                            dur_cnt <= '0;
                        end else if (ms_tick) begin
                            dur_cnt <= dur_cnt + DUR_W'(1);
                        end
                    end
                    default: begin
                        tone <= 1'b0;
                    end
                endcase
            end
        end

        assign busy[i]      = (state != ST_IDLE);
        assign tone_bits[i] = tone;
        assign play_nxt[i]  = (state_nxt == ST_PLAY);
        // A starting channel reports the incoming code on the same edge it
        // enters PLAY, so code_sound tracks the state register exactly.
        assign code_nxt[i]  = start ? code_in : code_q;
    end

    // ------------------------------------------------------------------------
    // code_sound: code of the lowest-index channel that will be in PLAY
    // ------------------------------------------------------------------------
    logic [CODE_W-1:0] code_sound_nxt;

    // Scan from the top so the lowest index overwrites and wins.
    always_comb begin
        code_sound_nxt = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (play_nxt[i]) begin
                code_sound_nxt = code_nxt[i];
            end
        end
    end

    // Register code_sound alongside the channel states.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            code_sound <= '0;
        end else begin
            code_sound <= code_sound_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Sigma-delta mixer
    // ------------------------------------------------------------------------
    logic [LVL_W-1:0] level;
    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] acc_sum;

    // Number of channels whose tone bit is currently high.
    always_comb begin
        level = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            level = level + LVL_W'(tone_bits[i]);
        end
    end

    assign acc_sum = SUM_W'(acc) + SUM_W'(level);

    // First-order modulator: emit a 1 and subtract CHANNELS whenever the
    // accumulator crosses CHANNELS. Mute silences and restarts from zero.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc   <= '0;
            sound <= 1'b0;
        end else if (mute) begin
            acc   <= '0;
            sound <= 1'b0;
        end else if (acc_sum >= CH_SUM) begin
            acc   <= ACC_W'(acc_sum - CH_SUM);
            sound <= 1'b1;
        end else begin
            acc   <= ACC_W'(acc_sum);
            sound <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tone_mixer
//  Purpose  : Directed self-checking bench for tone_mixer with a small clock
//             (16 clk per ms, half-periods 8/4/2, 4 ms tone, 2 ms gap).
//  Revision : 1.0
// ============================================================================
module tb_tone_mixer;

    logic       clk;
    logic       clr;
    logic       mute;
    logic [1:0] trig;
    logic [3:0] code;
    logic [1:0] busy;
    logic [1:0] code_sound;
    logic       sound;

    int vec_count;
    int err_count;

    tone_mixer #(
        .CLK_HZ    (16000),
        .CHANNELS  (2),
        .CODE_W    (2),
        .BASE_HALF (8),
        .DUR_MS    (4),
        .GAP_MS    (2)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .mute       (mute),
        .trig       (trig),
        .code       (code),
        .busy       (busy),
        .code_sound (code_sound),
        .sound      (sound)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle mute pulse while idle to bring the accumulator to zero.
    task automatic clear_acc();
        mute = 1'b1;
        step();
        mute = 1'b0;
    endtask

    // Play code cd on channel 0 (accumulator known zero) and check the tone
    // pattern, the PLAY and GAP lengths, and optionally that retriggers in
    // PLAY and in GAP are ignored.
    task automatic run_ch0(input string nm, input logic [1:0] cd, input bit retrig);
        int ones;
        int cs_bad;
        int play_len;
        int gap_len;
        int late_busy;
        code = {2'b00, cd};
        trig = 2'b01;
        step();
        trig = 2'b00;
        check({nm, "_start_busy"}, 32'(busy), 32'd1);
        check({nm, "_start_cs"}, 32'(code_sound), 32'(cd));
        ones   = 0;
        cs_bad = 0;
        for (int k = 1; k <= 48; k++) begin
            step();
            if (retrig && k == 20) begin
                code = 4'b0010;
                trig = 2'b01;
            end else begin
                trig = 2'b00;
            end
            ones = ones + 32'(sound);
            if (code_sound != cd) cs_bad++;
            if (k == 9)  check({nm, "_sound_e9"}, 32'(sound), 32'd0);
            if (k == 10) check({nm, "_sound_e10"}, 32'(sound), 32'd1);
        end
        trig = 2'b00;
        check({nm, "_ones_48"}, 32'(ones), 32'd12);
        check({nm, "_cs_steady"}, 32'(cs_bad), 32'd0);
        play_len = 49;
        for (int g = 0; g < 100 && code_sound == cd; g++) begin
            step();
            if (code_sound == cd) play_len++;
        end
        check({nm, "_play_len_in_49_64"}, 32'(play_len >= 49 && play_len <= 64), 32'd1);
        gap_len = 0;
        for (int g = 0; g < 100 && busy != 2'b00; g++) begin
            gap_len++;
            trig = (retrig && g == 3) ? 2'b01 : 2'b00;
            step();
        end
        trig = 2'b00;
        check({nm, "_gap_len_in_17_32"}, 32'(gap_len >= 17 && gap_len <= 32), 32'd1);
        late_busy = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (busy != 2'b00) late_busy++;
        end
        check({nm, "_idle_after"}, 32'(late_busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int split;
        int ones;
        int side;
        vec_count = 0;
        err_count = 0;
        clr  = 1'b0;
        mute = 1'b0;
        trig = 2'b00;
        code = 4'b0000;

        // 1. Reset state and quiet idle.
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cs", 32'(code_sound), 32'd0);
        check("rst_sound", 32'(sound), 32'd0);
        clr = 1'b1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (busy != 2'b00 || code_sound != 2'b00 || sound != 1'b0) bad++;
        end
        check("idle_200", 32'(bad), 32'd0);

        // 2. Single channel, code 1.
        run_ch0("c1", 2'd1, 1'b0);

        // 3. Two channels on the same edge, codes 3 and 2.
        code = 4'b1011;
        trig = 2'b11;
        step();
        trig = 2'b00;
        check("dual_busy", 32'(busy), 32'd3);
        check("dual_cs", 32'(code_sound), 32'd3);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) check("dual_sound_e7", 32'(sound), 32'd1);
            if (k == 8) check("dual_sound_e8", 32'(sound), 32'd1);
        end
        check("dual_cs_e8", 32'(code_sound), 32'd3);
        split = 0;
        for (int g = 0; g < 200 && busy != 2'b00; g++) begin
            if (busy == 2'b01 || busy == 2'b10) split++;
            step();
        end
        check("dual_end_busy", 32'(busy), 32'd0);
        check("dual_end_together", 32'(split), 32'd0);

        // 4. Retrigger with code 2 during PLAY and GAP is ignored.
        clear_acc();
        run_ch0("rt", 2'd1, 1'b1);

        // 5. Mute for 20 cycles mid-tone.
        clear_acc();
        code = 4'b0001;
        trig = 2'b01;
        step();
        trig = 2'b00;
        ones = 0;
        side = 0;
        for (int k = 1; k <= 31; k++) begin
            step();
            if (k >= 10 && k <= 29) begin
                ones = ones + 32'(sound);
                if (busy != 2'b01 || code_sound != 2'd1) side++;
            end
            if (k == 30) check("mute_rel_e30", 32'(sound), 32'd0);
            if (k == 31) check("mute_rel_e31", 32'(sound), 32'd1);
            if (k == 9)  mute = 1'b1;
            if (k == 29) mute = 1'b0;
        end
        check("mute_silent", 32'(ones), 32'd0);
        check("mute_state_kept", 32'(side), 32'd0);
        for (int g = 0; g < 200 && busy != 2'b00; g++) step();
        check("mute_done", 32'(busy), 32'd0);

        // 6. Asynchronous reset mid-PLAY, then clean restart.
        code = 4'b1001;
        trig = 2'b11;
        step();
        trig = 2'b00;
        repeat (12) step();
        #3;
        clr = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cs", 32'(code_sound), 32'd0);
        check("arst_sound", 32'(sound), 32'd0);
        repeat (2) step();
        #3;
        clr = 1'b1;
        step();
        code = 4'b0000;
        trig = 2'b01;
        step();
        trig = 2'b00;
        check("code0_busy", 32'(busy), 32'd0);
        check("code0_cs", 32'(code_sound), 32'd0);
        code = 4'b0001;
        trig = 2'b01;
        step();
        trig = 2'b00;
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_cs", 32'(code_sound), 32'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 9)  check("restart_e9", 32'(sound), 32'd0);
            if (k == 10) check("restart_e10", 32'(sound), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
`default_nettype wire
